apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
Parametrised APB3 slave fronting a word-addressed register memory. It replaces the fixed 8-bit/256-entry combinational slave. It adds:
- a registered access state machine,
- programmable wait states,
- per-byte write strobes,
- PSLVERR on out-of-range addresses.

It sits on the APB bus behind the apb_master/bridge as a generic peripheral-memory endpoint.

Parameters:
ADDR_WIDTH, 8, width of paddr (word address)
DATA_WIDTH, 32, width of pwdata/prdata; must be a multiple of 8
DEPTH, 256, number of memory words; must be <= 2**ADDR_WIDTH
WAIT_STATES, 0, extra access-phase cycles before pready; 0..15

Ports:
pclk  input  1  APB clock; all state on rising edge
presetn  input  1  asynchronous active-low reset
pselx  input  1  slave select
penable  input  1  access-phase indicator
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_WIDTH  word address
pwdata  input  DATA_WIDTH  write data
pstrb  input  DATA_WIDTH/8  byte-lane write enables; ignored on reads
prdata  output  DATA_WIDTH  read data, valid when pready=1 and read
pready  output  1  transfer completes this cycle
pslverr  output  1  error response, valid when pready=1

Behaviour:
Reset and outputs:
- One clock domain: pclk. Reset is asynchronous and active-low on presetn.
- While presetn=0: state=IDLE, wait counter=0, prdata=0, pready=0, pslverr=0. Memory contents are not reset (undefined until written).
- All outputs are driven from registers only. There is no combinational path from inputs to outputs.

FSM states: IDLE, ACCESS.
- IDLE: pready=0, pslverr=0, prdata=0.
  - On an edge with pselx=1 and penable=0 (setup phase), capture into holding registers: addr_q, write_q, wdata_q, strb_q, err_q = (paddr >= DEPTH).
  - On that same edge, load cnt=WAIT_STATES, prefetch rdata_q = mem[paddr] (0 if out of range), and go to ACCESS.
  - Any other input combination stays in IDLE.
- ACCESS: pready = (cnt==0); pslverr = (cnt==0) & err_q; prdata = (cnt==0 & !write_q & !err_q) ? rdata_q : 0.
  - Edge with pselx=1, penable=1, cnt!=0: decrement cnt, stay in ACCESS.
  - Edge with pselx=1, penable=1, cnt==0: complete the transfer, go to IDLE.
    - On completion, if write_q and !err_q, each byte lane i with strb_q[i]=1 is written: mem[addr_q][8i+7:8i] <= wdata_q[8i+7:8i].
    - Lanes with strb_q[i]=0 are unchanged.
  - Edge with pselx=0 (protocol abort): go to IDLE, no memory write, no response.

Latency and timing:
- Access latency: pready rises WAIT_STATES+1 cycles after the setup edge. With WAIT_STATES=0, pready=1 in the first access cycle (standard 2-cycle APB transfer).
- paddr, pwdata, pwrite and pstrb changes during ACCESS are ignored; only the values latched in setup are used.
- Back-to-back transfers: after completion the FSM is in IDLE and accepts the next setup cycle immediately, giving one transfer per 2+WAIT_STATES cycles.
- Read-after-write to the same address: the prefetch at the next setup edge sees the written data, because the write completed on the earlier edge.

Boundary conditions:
- paddr >= DEPTH: pslverr=1 with pready. Writes are suppressed; reads return 0.
- pstrb=0 on a write: completes with pready=1 and pslverr=0; memory unchanged.
- presetn asserted mid-transfer: immediate return to IDLE, outputs cleared, pending write discarded.

Test Plan:
1. Reset with presetn=0 held 3 cycles -> prdata=0, pready=0, pslverr=0; after release the FSM is in IDLE.
2. WAIT_STATES=0: write 0xDEADBEEF to addr 0x10 with pstrb=4'hF, then read 0x10 -> each transfer takes 2 cycles; pready=1 in the access cycle; read prdata=0xDEADBEEF, pslverr=0.
3. Partial write to 0x10 with pwdata=0x11223344, pstrb=4'b0101, then read -> prdata=0xDE22BE44.
4. WAIT_STATES=3, read of 0x10 -> pready low for exactly 3 access cycles, high on the 4th with prdata valid. Change paddr during the wait -> no effect on the result.
5. DEPTH=200: write to addr 250, then read addr 250 -> both complete with pready=1 and pslverr=1; read prdata=0; entries 0..199 unchanged.
6. Deassert pselx during the wait states of a write to addr 5 -> FSM returns to IDLE with no pready; a subsequent read of addr 5 returns the prior contents. Assert presetn=0 mid-access -> outputs clear asynchronously.

Source files
------------

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a master/bridge and the apb_slave_mem endpoint.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    pselx;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

  modport master (
    output pselx, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 slave over a word-addressed memory: registered setup/access FSM,
// programmable wait states, byte strobes and PSLVERR for out-of-range words.
module apb_slave_mem_lane #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  pclk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [7:0]            rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge pclk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            pclk,
  input  logic            presetn,
  apb_slave_mem_if.slave  bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [0:0]                    state;
  logic [3:0]                    cnt;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic                          write_q;
  logic [NUM_LANES-1:0][7:0]     wdata_q;
  logic [NUM_LANES-1:0]          strb_q;
  logic                          err_q;
  logic [DATA_WIDTH-1:0]         rdata_q;
  logic [NUM_LANES-1:0][7:0]     rd_lane;
  logic                          setup, in_err, done, wr_fire;

  assign setup   = bus.pselx & ~bus.penable;
  assign in_err  = {1'b0, bus.paddr} >= DEPTH_L;
  assign done    = (state == ACCESS) && (cnt == 4'd0);
  // Commit only on the completing edge; an abort or reset drops the write.
  assign wr_fire = done & bus.pselx & bus.penable & write_q & ~err_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    apb_slave_mem_lane #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_lane (
      .pclk  (pclk),
      .we    (wr_fire & strb_q[i]),
      .waddr (addr_q),
      .wdata (wdata_q[i]),
      .raddr (bus.paddr),
      .rdata (rd_lane[i])
    );
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (setup) begin
          addr_q  <= bus.paddr;
          write_q <= bus.pwrite;
          wdata_q <= bus.pwdata;
          strb_q  <= bus.pstrb;
          err_q   <= in_err;
          cnt     <= 4'(WAIT_STATES);
          rdata_q <= in_err ? '0 : rd_lane;
          state   <= ACCESS;
        end
        default: begin
          if (!bus.pselx)          state <= IDLE;
          else if (bus.penable) begin
            if (cnt != 4'd0)       cnt   <= cnt - 4'd1;
            else                   state <= IDLE;
          end
        end
      endcase
    end
  end

  // Outputs decode registered state only; no input-to-output path.
  assign bus.pready  = done;
  assign bus.pslverr = done & err_q;
  assign bus.prdata  = (done & ~write_q & ~err_q) ? rdata_q : '0;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: dut a (0 wait states, 256 words), dut b (3 wait states, 200 words).
module tb_apb_slave_mem;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_a ();
  apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_b ();

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_a (
    .pclk(pclk), .presetn(presetn), .bus(if_a.slave));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200), .WAIT_STATES(3)) u_b (
    .pclk(pclk), .presetn(presetn), .bus(if_b.slave));

  task automatic drive(input int w, input bit sel, input bit en, input bit wr,
                       input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (w == 0) begin
      if_a.pselx = sel; if_a.penable = en; if_a.pwrite = wr;
      if_a.paddr = a; if_a.pwdata = d; if_a.pstrb = s;
    end else begin
      if_b.pselx = sel; if_b.penable = en; if_b.pwrite = wr;
      if_b.paddr = a; if_b.pwdata = d; if_b.pstrb = s;
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? if_a.pready : if_b.pready;
  endfunction

  // Full transfer; chg scrambles paddr/pwdata during wait cycles.
  task automatic xfer(input int w, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit chg,
                      output logic [31:0] rd, output logic err, output int waits, output bit to);
    drive(w, 1, 0, wr, a, d, s);
    @(posedge pclk); #1;
    drive(w, 1, 1, wr, a, d, s);
    waits = 0; to = 0;
    @(negedge pclk);
    while (rdy(w) !== 1'b1) begin
      if (waits >= 20) begin to = 1; break; end
      waits++;
      if (chg) drive(w, 1, 1, ~wr, a ^ 8'h01, ~d, ~s);
      @(negedge pclk);
    end
    rd  = (w == 0) ? if_a.prdata  : if_b.prdata;
    err = (w == 0) ? if_a.pslverr : if_b.pslverr;
    @(posedge pclk); #1;
    drive(w, 0, 0, 0, 8'h00, 32'h0, 4'h0);
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 8'h00, 32'h0, 4'h0);
    drive(1, 0, 0, 0, 8'h00, 32'h0, 4'h0);
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    tests++; if (if_a.pready !== 1'b0) begin fails++; $display("FAIL rst_pready_a got %b exp 0", if_a.pready); end
    tests++; if (if_a.pslverr !== 1'b0) begin fails++; $display("FAIL rst_pslverr_a got %b exp 0", if_a.pslverr); end
    tests++; if (if_a.prdata !== 32'h0) begin fails++; $display("FAIL rst_prdata_a got %h exp 0", if_a.prdata); end
    tests++; if (if_b.pready !== 1'b0) begin fails++; $display("FAIL rst_pready_b got %b exp 0", if_b.pready); end
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;
    tests++; if (if_a.pready !== 1'b0 || if_b.pready !== 1'b0) begin
      fails++; $display("FAIL idle_after_rst got %b/%b exp 0/0", if_a.pready, if_b.pready); end
  endtask

  task automatic test_basic;
    logic [31:0] rd; logic err; int waits; bit to;
    xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, rd, err, waits, to);
    tests++; if (to || waits != 0) begin fails++; $display("FAIL basic_wr_waits got %0d exp 0", waits); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL basic_wr_err got %b exp 0", err); end
    @(negedge pclk);
    tests++; if (if_a.pready !== 1'b0) begin fails++; $display("FAIL basic_idle_pready got %b exp 0", if_a.pready); end
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (to || waits != 0) begin fails++; $display("FAIL basic_rd_waits got %0d exp 0", waits); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_rd got %h exp DEADBEEF", rd); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL basic_rd_err got %b exp 0", err); end
  endtask

  task automatic test_strobe;
    logic [31:0] rd; logic err; int waits; bit to;
    xfer(0, 1, 8'h10, 32'h11223344, 4'b0101, 0, rd, err, waits, to);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (rd !== 32'hDE22BE44) begin fails++; $display("FAIL partial_rd got %h exp DE22BE44", rd); end
    xfer(0, 1, 8'h10, 32'hFFFFFFFF, 4'h0, 0, rd, err, waits, to);
    tests++; if (to || err !== 1'b0) begin fails++; $display("FAIL strb0_err got %b exp 0", err); end
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (rd !== 32'hDE22BE44) begin fails++; $display("FAIL strb0_rd got %h exp DE22BE44", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic err; int waits; bit to;
    xfer(0, 1, 8'h03, 32'hA5A5C3C3, 4'hF, 0, rd, err, waits, to);
    xfer(0, 0, 8'h03, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (rd !== 32'hA5A5C3C3) begin fails++; $display("FAIL b2b_raw got %h exp A5A5C3C3", rd); end
    xfer(0, 1, 8'h04, 32'h01020304, 4'hF, 0, rd, err, waits, to);
    xfer(0, 0, 8'h03, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (rd !== 32'hA5A5C3C3) begin fails++; $display("FAIL b2b_neighbor got %h exp A5A5C3C3", rd); end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd; logic err; int waits; bit to;
    xfer(1, 1, 8'h10, 32'hCAFEF00D, 4'hF, 1, rd, err, waits, to);
    tests++; if (to || waits != 3) begin fails++; $display("FAIL ws_wr_waits got %0d exp 3", waits); end
    xfer(1, 1, 8'h11, 32'h0BADBEEF, 4'hF, 0, rd, err, waits, to);
    xfer(1, 0, 8'h10, 32'h0, 4'h0, 1, rd, err, waits, to);
    tests++; if (to || waits != 3) begin fails++; $display("FAIL ws_rd_waits got %0d exp 3", waits); end
    tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL ws_rd got %h exp CAFEF00D", rd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic err; int waits; bit to;
    xfer(1, 1, 8'd199, 32'h12345678, 4'hF, 0, rd, err, waits, to);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL oob_199_wr_err got %b exp 0", err); end
    xfer(1, 1, 8'd250, 32'hFFFFFFFF, 4'hF, 0, rd, err, waits, to);
    tests++; if (to || err !== 1'b1) begin fails++; $display("FAIL oob_wr_err got %b exp 1", err); end
    xfer(1, 0, 8'd250, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (to || err !== 1'b1) begin fails++; $display("FAIL oob_rd_err got %b exp 1", err); end
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL oob_rd_data got %h exp 0", rd); end
    xfer(1, 0, 8'd200, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL oob_200_err got %b exp 1", err); end
    xfer(1, 0, 8'd199, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (rd !== 32'h12345678 || err !== 1'b0) begin
      fails++; $display("FAIL oob_199_rd got %h/%b exp 12345678/0", rd, err); end
    xfer(1, 0, 8'h10, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL oob_10_intact got %h exp CAFEF00D", rd); end
    xfer(0, 0, 8'hFF, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL top_word_err got %b exp 0", err); end
  endtask

  task automatic test_abort;
    logic [31:0] rd; logic err; int waits; bit to; int seen;
    xfer(1, 1, 8'd5, 32'h55AA55AA, 4'hF, 0, rd, err, waits, to);
    drive(1, 1, 0, 1, 8'd5, 32'h00000000, 4'hF);
    @(posedge pclk); #1;
    drive(1, 1, 1, 1, 8'd5, 32'h00000000, 4'hF);
    @(posedge pclk); #1;
    drive(1, 0, 0, 0, 8'd0, 32'h0, 4'h0);
    seen = 0;
    repeat (6) begin @(negedge pclk); if (if_b.pready !== 1'b0) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_pready got %0d ready cycles exp 0", seen); end
    @(posedge pclk); #1;
    xfer(1, 0, 8'd5, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (rd !== 32'h55AA55AA) begin fails++; $display("FAIL abort_rd got %h exp 55AA55AA", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic err; int waits; bit to;
    drive(0, 1, 0, 0, 8'h10, 32'h0, 4'h0);
    drive(1, 1, 0, 1, 8'd5, 32'h00000000, 4'hF);
    @(posedge pclk); #1;
    drive(0, 1, 1, 0, 8'h10, 32'h0, 4'h0);
    drive(1, 1, 1, 1, 8'd5, 32'h00000000, 4'hF);
    @(negedge pclk);
    tests++; if (if_a.pready !== 1'b1 || if_a.prdata !== 32'hDE22BE44) begin
      fails++; $display("FAIL mid_pre got %b/%h exp 1/DE22BE44", if_a.pready, if_a.prdata); end
    #2 presetn = 1'b0;
    #1;
    tests++; if (if_a.pready !== 1'b0 || if_a.prdata !== 32'h0 || if_b.pready !== 1'b0) begin
      fails++; $display("FAIL mid_rst got %b/%h/%b exp 0/0/0", if_a.pready, if_a.prdata, if_b.pready); end
    drive(0, 0, 0, 0, 8'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 0, 8'h0, 32'h0, 4'h0);
    repeat (2) @(posedge pclk);
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1, 0, 8'd5, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (rd !== 32'h55AA55AA) begin fails++; $display("FAIL mid_rst_discard got %h exp 55AA55AA", rd); end
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 0, rd, err, waits, to);
    tests++; if (rd !== 32'hDE22BE44) begin fails++; $display("FAIL mid_rst_mem got %h exp DE22BE44", rd); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_strobe;
    test_back_to_back;
    test_wait_states;
    test_out_of_range;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
